// File: rtl/fma_unpack_seq_if.sv
// Operand/result handshake bundle for the fma16 operand unpacker.
interface fma_unpack_seq_if #(
  parameter int NE = 5,
  parameter int NF = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NE+NF:0]       x;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic signed [NE+1:0] out_exp;
  logic [NF:0]          out_mant;
  logic                 out_zero;
  logic                 out_subnorm;
  logic                 out_inf;
  logic                 out_nan;
  logic                 out_snan;

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant,
    input  out_zero, out_subnorm, out_inf, out_nan, out_snan
  );

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant,
    output out_zero, out_subnorm, out_inf, out_nan, out_snan
  );
endinterface

// File: rtl/fma_unpack_seq.sv
// Half-precision operand unpacker: classifies the packed word and normalises
// subnormals with a one-bit-per-cycle left shifter ahead of the fma datapath.
module fma_unpack_seq #(
  parameter int NE = 5,
  parameter int NF = 10
) (
  input logic            clk,
  input logic            reset_n,
  fma_unpack_seq_if.slave bus
);
  localparam int EW = NE + 2;
  localparam int CW = $clog2(NF + 1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t               state, state_next;
  logic                 sign;
  logic signed [EW-1:0] exp;
  logic [NF:0]          mant;
  logic                 zero, subnorm, inf, nan, snan;
  logic [CW-1:0]        cnt;

  logic [NE-1:0]        e_in;
  logic [NF-1:0]        f_in;
  logic                 e_zero, e_ones, f_zero;
  logic                 accept;
  state_t               load_state;
  logic signed [EW-1:0] ld_exp;
  logic [NF:0]          ld_mant;
  logic                 ld_zero, ld_subnorm, ld_inf, ld_nan, ld_snan;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CW'(NF)) ? v : v + CW'(1);
  endfunction

  assign e_in   = bus.x[NE+NF-1:NF];
  assign f_in   = bus.x[NF-1:0];
  assign e_zero = (e_in == '0);
  assign e_ones = &e_in;
  assign f_zero = (f_in == '0);

  assign bus.in_ready = reset_n & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;
  assign load_state   = (e_zero & ~f_zero) ? NORM : DONE;

  always_comb begin
    ld_exp     = $signed({2'b00, e_in});
    ld_mant    = {1'b1, f_in};
    ld_zero    = 1'b0;
    ld_subnorm = 1'b0;
    ld_inf     = 1'b0;
    ld_nan     = 1'b0;
    ld_snan    = 1'b0;
    if (e_zero) begin
      // Subnormals start at exponent 1 and walk down as the shifter normalises.
      ld_exp     = f_zero ? '0 : EW'(1);
      ld_mant    = {1'b0, f_in};
      ld_zero    = f_zero;
      ld_subnorm = ~f_zero;
    end else if (e_ones) begin
      ld_inf  = f_zero;
      ld_nan  = ~f_zero;
      ld_snan = ~f_zero & ~f_in[NF-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = load_state;
      // Leave on the shift that brings the leading one into place.
      NORM: if (mant[NF] | mant[NF-1]) state_next = DONE;
      DONE: if (bus.out_ready) state_next = accept ? load_state : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sign    <= 1'b0;
      exp     <= '0;
      mant    <= '0;
      zero    <= 1'b0;
      subnorm <= 1'b0;
      inf     <= 1'b0;
      nan     <= 1'b0;
      snan    <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      sign    <= bus.x[NE+NF];
      exp     <= ld_exp;
      mant    <= ld_mant;
      zero    <= ld_zero;
      subnorm <= ld_subnorm;
      inf     <= ld_inf;
      nan     <= ld_nan;
      snan    <= ld_snan;
      cnt     <= '0;
    end else if ((state == NORM) && !mant[NF]) begin
      mant <= mant << 1;
      exp  <= exp - $signed(EW'(1));
      cnt  <= sat_inc(cnt);
    end
  end

  assign bus.out_valid   = (state == DONE);
  assign bus.out_sign    = sign;
  assign bus.out_exp     = exp;
  assign bus.out_mant    = mant;
  assign bus.out_zero    = zero;
  assign bus.out_subnorm = subnorm;
  assign bus.out_inf     = inf;
  assign bus.out_nan     = nan;
  assign bus.out_snan    = snan;
endmodule

// File: tb/tb_fma_unpack_seq.sv
// Directed and randomised-stream bench for the fma16 operand unpacker.
module tb_fma_unpack_seq;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  fma_unpack_seq_if #(.NE(5), .NF(10)) bus ();

  fma_unpack_seq #(.NE(5), .NF(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // {sign, exp[6:0], mant[10:0], zero, subnorm, inf, nan, snan}
  function automatic logic [23:0] observed();
    return {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_zero,
            bus.out_subnorm, bus.out_inf, bus.out_nan, bus.out_snan};
  endfunction

  function automatic logic [23:0] ref_unpack(input logic [15:0] v);
    logic [4:0]  e;
    logic [9:0]  f;
    logic [6:0]  ex;
    logic [10:0] m;
    logic [4:0]  fl;
    int          k;
    e = v[14:10];
    f = v[9:0];
    if (e == 5'd0 && f == 10'd0) begin
      ex = 7'd0; m = 11'd0; fl = 5'b10000;
    end else if (e == 5'd0) begin
      k = 0;
      while (!f[9-k]) k++;
      ex = 7'(-k);
      m  = 11'({1'b0, f}) << (k + 1);
      fl = 5'b01000;
    end else if (e == 5'd31) begin
      ex = 7'd31;
      if (f == 10'd0) begin m = 11'h400; fl = 5'b00100; end
      else begin m = {1'b1, f}; fl = {3'b000, 1'b1, ~f[9]}; end
    end else begin
      ex = {2'b00, e}; m = {1'b1, f}; fl = 5'b00000;
    end
    return {v[15], ex, m, fl};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] v, input int lat_want,
                        input logic [23:0] want);
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.x         = v;
    bus.in_valid  = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 30);
    chk({tag, "_latency"}, 32'(lat), 32'(lat_want));
    chk({tag, "_result"}, 32'(observed()), 32'(want));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_retired"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] q[$];
    logic [23:0] exp_item;
    logic [15:0] rv;
    int          sent, received, cycles, seen;
    checks = 0;
    errors = 0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x        = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_outputs", 32'(observed()), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("one",     16'h3C00, 1,  {1'b0, 7'd15,  11'h400, 5'b00000});
    run_op("normal",  16'h3555, 1,  {1'b0, 7'd13,  11'h555, 5'b00000});
    run_op("sub_min", 16'h0001, 11, {1'b0, 7'h77,  11'h400, 5'b01000});
    run_op("sub_top", 16'h0200, 2,  {1'b0, 7'd0,   11'h400, 5'b01000});
    run_op("sub_mid", 16'h0030, 6,  {1'b0, 7'h7C,  11'h600, 5'b01000});
    run_op("negzero", 16'h8000, 1,  {1'b1, 7'd0,   11'h000, 5'b10000});
    run_op("inf",     16'h7C00, 1,  {1'b0, 7'd31,  11'h400, 5'b00100});
    run_op("snan",    16'h7D00, 1,  {1'b0, 7'd31,  11'h500, 5'b00011});
    run_op("qnan",    16'hFE00, 1,  {1'b1, 7'd31,  11'h600, 5'b00010});

    // Backpressure hold, then back-to-back acceptance on retire.
    @(negedge clk);
    bus.x = 16'h3C00;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", 32'(observed()), 32'({1'b0, 7'd15, 11'h400, 5'b00000}));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x         = 16'h4000;
    #1;
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_data", 32'(observed()), 32'({1'b0, 7'd16, 11'h400, 5'b00000}));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset during the fourth NORM cycle discards the operand.
    bus.x = 16'h0001;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("norm_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_outputs", 32'(observed()), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("midrst_release_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_stale", 32'(seen), 32'd0);

    // Random stream against the reference model.
    sent = 0;
    received = 0;
    cycles = 0;
    while ((sent < 1000 || received < sent) && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (!bus.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        rv = 16'($urandom);
        if ($urandom_range(0, 3) == 0) rv[14:10] = 5'd0;
        bus.x = rv;
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected", 32'(observed()), 32'hFFFFFFFF);
        end else begin
          exp_item = q.pop_front();
          chk("rand_result", 32'(observed()), 32'(exp_item));
        end
        received++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_unpack(bus.x));
        sent++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
      end
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_received", 32'(received), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
